// File: rtl/alu_sequencer_pkg.sv
// Shared types for the ALU sequencer: op codes, operand modes, FSM states, flag positions.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_ADC  = 4'd0,
    OP_SBC  = 4'd1,
    OP_AND  = 4'd2,
    OP_ORA  = 4'd3,
    OP_EOR  = 4'd4,
    OP_ASL  = 4'd5,
    OP_LSR  = 4'd6,
    OP_ROL  = 4'd7,
    OP_ROR  = 4'd8,
    OP_CMP  = 4'd9,
    OP_PASS = 4'd10
  } alu_op_t;

  typedef enum logic [1:0] {
    MODE_IMM = 2'd0,
    MODE_MEM = 2'd1,
    MODE_RMW = 2'd2,
    MODE_ILL = 2'd3
  } seq_mode_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } seq_state_t;

  // Bit positions inside status = {N,V,Z,C}
  localparam int ST_N = 3;
  localparam int ST_V = 2;
  localparam int ST_Z = 1;
  localparam int ST_C = 0;

  localparam logic [3:0] OP_MAX = 4'd10;

  function automatic logic is_shift(alu_op_t op);
    return (op == OP_ASL) || (op == OP_LSR) || (op == OP_ROL) || (op == OP_ROR);
  endfunction

  // Raw request fields are checked before casting: op codes above OP_MAX have no enum member.
  function automatic logic is_legal(logic [3:0] op, logic [1:0] mode);
    logic ok;
    ok = (op <= OP_MAX) && (mode != MODE_ILL);
    if ((mode == MODE_RMW) && !is_shift(alu_op_t'(op))) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request and memory bus bundle between a requester/memory and the ALU sequencer.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready; memory reads return data the cycle after mem_rd.
interface alu_sequencer_if;

  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [1:0]  req_mode;
  logic [7:0]  req_imm;
  logic [15:0] req_addr;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  acc;
  logic [3:0]  status;
  logic        done;
  logic        err;

  // master: requester plus memory model; slave: the sequencer
  modport master (
    output req_valid, req_op, req_mode, req_imm, req_addr, mem_rdata,
    input  req_ready, mem_addr, mem_rd, mem_wr, mem_wdata, acc, status, done, err
  );

  modport slave (
    input  req_valid, req_op, req_mode, req_imm, req_addr, mem_rdata,
    output req_ready, mem_addr, mem_rd, mem_wr, mem_wdata, acc, status, done, err
  );

endinterface

// File: rtl/alu_sequencer_alu.sv
// Combinational 8-bit ALU: add/sub with carry, logic ops, shifts/rotates, compare, pass.
// Latency: 0 cycles (pure combinational).
// Backpressure: none. Ports: op_i, a_i, b_i, cin_i in; result_o plus cout/overflow/zero/negative out.
module alu
  import cpu_pkg::*;
(
  input  alu_op_t    op_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] result_o,
  output logic       cout_o,
  output logic       overflow_o,
  output logic       zero_o,
  output logic       negative_o
);

  logic [8:0] sum;

  always_comb begin
    sum        = 9'd0;
    result_o   = 8'h00;
    cout_o     = 1'b0;
    overflow_o = 1'b0;
    case (op_i)
      OP_ADC: begin
        sum        = {1'b0, a_i} + {1'b0, b_i} + {8'd0, cin_i};
        result_o   = sum[7:0];
        cout_o     = sum[8];
        overflow_o = (a_i[7] == b_i[7]) && (result_o[7] != a_i[7]);
      end
      // Subtract as add-of-complement: carry set means no borrow.
      OP_SBC: begin
        sum        = {1'b0, a_i} + {1'b0, ~b_i} + {8'd0, cin_i};
        result_o   = sum[7:0];
        cout_o     = sum[8];
        overflow_o = (a_i[7] != b_i[7]) && (result_o[7] != a_i[7]);
      end
      // Compare ignores the incoming carry.
      OP_CMP: begin
        sum      = {1'b0, a_i} + {1'b0, ~b_i} + 9'd1;
        result_o = sum[7:0];
        cout_o   = sum[8];
      end
      OP_AND:  result_o = a_i & b_i;
      OP_ORA:  result_o = a_i | b_i;
      OP_EOR:  result_o = a_i ^ b_i;
      OP_ASL: begin
        result_o = {a_i[6:0], 1'b0};
        cout_o   = a_i[7];
      end
      OP_LSR: begin
        result_o = {1'b0, a_i[7:1]};
        cout_o   = a_i[0];
      end
      OP_ROL: begin
        result_o = {a_i[6:0], cin_i};
        cout_o   = a_i[7];
      end
      OP_ROR: begin
        result_o = {cin_i, a_i[7:1]};
        cout_o   = a_i[0];
      end
      OP_PASS: result_o = b_i;
      default: result_o = 8'h00;
    endcase
  end

  assign zero_o     = (result_o == 8'h00);
  assign negative_o = result_o[7];

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one ALU request through optional memory read, execute and write-back; holds A and {N,V,Z,C}.
// Latency: done at accept+1 (IMM), +2 (MEM), +3 (RMW); err at accept+1 for illegal requests.
// Backpressure: req_ready only in IDLE; requests while busy are ignored. Ports: clk, rst_n, bus (slave).
module alu_sequencer
  import cpu_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  alu_sequencer_if.slave bus
);

  seq_state_t  state_q, state_d;
  alu_op_t     op_q, op_d;
  seq_mode_t   mode_q, mode_d;
  logic [7:0]  imm_q, imm_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  acc_q, acc_d;
  logic [3:0]  status_q, status_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        err_q, err_d;

  logic [7:0]  alu_a, alu_b, alu_res;
  logic        alu_c, alu_v, alu_z, alu_n;
  logic        shift_op;

  // Shifts work on the accumulator in IMM mode and on the fetched byte otherwise;
  // two-operand ops always take A plus the immediate or fetched byte.
  always_comb begin
    shift_op = is_shift(op_q);
    alu_a    = (shift_op && (mode_q != MODE_IMM)) ? bus.mem_rdata : acc_q;
    alu_b    = (mode_q == MODE_IMM) ? imm_q : bus.mem_rdata;
  end

  alu u_alu (
    .op_i       (op_q),
    .a_i        (alu_a),
    .b_i        (alu_b),
    .cin_i      (status_q[ST_C]),
    .result_o   (alu_res),
    .cout_o     (alu_c),
    .overflow_o (alu_v),
    .zero_o     (alu_z),
    .negative_o (alu_n)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mode_d   = mode_q;
    imm_d    = imm_q;
    addr_d   = addr_q;
    acc_d    = acc_q;
    status_d = status_q;
    wdata_d  = wdata_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          op_d   = alu_op_t'(bus.req_op);
          mode_d = seq_mode_t'(bus.req_mode);
          imm_d  = bus.req_imm;
          addr_d = bus.req_addr;
          // Illegal requests are consumed here and never leave IDLE.
          if (is_legal(bus.req_op, bus.req_mode)) begin
            state_d = (bus.req_mode == MODE_IMM) ? S_EXEC : S_READ;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_READ: state_d = S_EXEC;
      S_EXEC: begin
        state_d = (mode_q == MODE_RMW) ? S_WRITE : S_IDLE;
        wdata_d = alu_res;
        case (op_q)
          OP_ADC, OP_SBC: begin
            acc_d    = alu_res;
            status_d = {alu_n, alu_v, alu_z, alu_c};
          end
          OP_AND, OP_ORA, OP_EOR, OP_PASS: begin
            acc_d          = alu_res;
            status_d[ST_N] = alu_n;
            status_d[ST_Z] = alu_z;
          end
          OP_CMP: begin
            status_d[ST_N] = alu_n;
            status_d[ST_Z] = alu_z;
            status_d[ST_C] = alu_c;
          end
          OP_ASL, OP_LSR, OP_ROL, OP_ROR: begin
            if (mode_q == MODE_IMM) acc_d = alu_res;
            status_d[ST_N] = alu_n;
            status_d[ST_Z] = alu_z;
            status_d[ST_C] = alu_c;
          end
          default: ;
        endcase
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADC;
      mode_q   <= MODE_IMM;
      imm_q    <= 8'h00;
      addr_q   <= 16'h0000;
      acc_q    <= 8'h00;
      status_q <= 4'h0;
      wdata_q  <= 8'h00;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mode_q   <= mode_d;
      imm_q    <= imm_d;
      addr_q   <= addr_d;
      acc_q    <= acc_d;
      status_q <= status_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
    end
  end

  // Memory strobes and address decode straight from state, so nothing leaks outside READ/WRITE.
  always_comb begin
    bus.req_ready = (state_q == S_IDLE);
    bus.mem_rd    = (state_q == S_READ);
    bus.mem_wr    = (state_q == S_WRITE);
    bus.mem_addr  = (bus.mem_rd || bus.mem_wr) ? addr_q : 16'h0000;
    bus.mem_wdata = bus.mem_wr ? wdata_q : 8'h00;
    bus.acc       = acc_q;
    bus.status    = status_q;
    bus.done      = ((state_q == S_EXEC) && (mode_q != MODE_RMW)) || (state_q == S_WRITE);
    bus.err       = err_q;
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed scenarios plus random requests vs. an arithmetic model.
// Latency: n/a.
// Backpressure: driver holds req_valid until req_ready; memory model answers reads one cycle later.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_sequencer_if bus ();

  alu_sequencer u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          is_err;
    int          lat;
    int          acc_cyc;
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  acc;
    logic [3:0]  status;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;

  // Reference architectural state
  logic [7:0] m_acc = 8'h00;
  bit m_n = 0, m_v = 0, m_z = 0, m_c = 0;

  logic [7:0] mem [logic [15:0]];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // ---------------- memory model: data appears the cycle after the read strobe
  bit pend = 0;
  logic [7:0] pdata;
  always @(negedge clk) begin
    if (bus.mem_rd) begin
      pend  = 1'b1;
      pdata = mem[bus.mem_addr];
    end
  end
  always @(posedge clk) begin
    #1;
    if (pend) begin
      bus.mem_rdata = pdata;
      pend = 1'b0;
    end else begin
      bus.mem_rdata = 8'($urandom);
    end
  end

  // ---------------- reference model
  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  task automatic predict(input logic [3:0] op, input logic [1:0] mode, input logic [7:0] imm,
                         input logic [15:0] addr, input logic [7:0] rdata, output exp_t e);
    int a, b, c, r, sr;
    logic [7:0] res8;
    bit legal, shift;
    shift = (op >= 4'd5) && (op <= 4'd8);
    legal = !((op > 4'd10) || (mode == 2'd3) || ((mode == 2'd2) && !shift));
    e.is_err = !legal; e.acc_cyc = 0; e.addr = addr; e.wdata = 8'h00;
    e.rd = 0; e.wr = 0; e.lat = 1;
    if (legal) begin
      e.lat = (mode == 2'd0) ? 1 : (mode == 2'd1) ? 2 : 3;
      e.rd  = (mode != 2'd0);
      e.wr  = (mode == 2'd2);
      a = (shift && mode != 2'd0) ? {24'd0, rdata} : {24'd0, m_acc};
      b = (mode == 2'd0) ? {24'd0, imm} : {24'd0, rdata};
      c = {31'd0, m_c};
      r = 0;
      case (op)
        4'd0: begin r = a + b + c; sr = sx(a) + sx(b) + c; m_c = (r > 255); m_v = (sr > 127) || (sr < -128); end
        4'd1: begin r = a - b - (1 - c); sr = sx(a) - sx(b) - (1 - c); m_c = (r >= 0); m_v = (sr > 127) || (sr < -128); end
        4'd2: r = a & b;
        4'd3: r = a | b;
        4'd4: r = a ^ b;
        4'd5: begin r = a * 2;           m_c = (a >= 128); end
        4'd6: begin r = a / 2;           m_c = (a % 2) == 1; end
        4'd7: begin r = a * 2 + c;       m_c = (a >= 128); end
        4'd8: begin r = a / 2 + 128 * c; m_c = (a % 2) == 1; end
        4'd9: begin r = a - b;           m_c = (r >= 0); end
        default: r = b;
      endcase
      res8 = r[7:0];
      m_n = res8[7];
      m_z = (res8 == 8'h00);
      e.wdata = res8;
      // CMP never writes A; shifts write A only in IMM mode
      if (op != 4'd9 && !(shift && mode != 2'd0)) m_acc = res8;
    end
    e.acc    = m_acc;
    e.status = {m_n, m_v, m_z, m_c};
  endtask

  // ---------------- monitor / scoreboard
  exp_t chk, e_mon;
  bit   chk_pend = 0;
  int   rd_cnt = 0, wr_cnt = 0, rd_cyc = 0, wr_cyc = 0;
  logic [15:0] rd_addr, wr_addr;
  logic [7:0]  wr_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk_pend = 0; rd_cnt = 0; wr_cnt = 0;
    end else begin
      if (chk_pend) begin
        check("acc_after", bus.acc, chk.acc);
        check("status_after", bus.status, chk.status);
        chk_pend = 0;
      end
      check("rd_wr_exclusive", bus.mem_rd & bus.mem_wr, 0);
      if (!bus.mem_rd && !bus.mem_wr) check("addr_idle_zero", bus.mem_addr, 0);
      if (bus.mem_rd) begin rd_cnt++; rd_addr = bus.mem_addr; rd_cyc = cyc; end
      if (bus.mem_wr) begin wr_cnt++; wr_addr = bus.mem_addr; wr_data = bus.mem_wdata; wr_cyc = cyc; end
      if (bus.done || bus.err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", {bus.done, bus.err}, 0);
        end else begin
          e_mon = exp_q.pop_front();
          check("err_pulse", bus.err, e_mon.is_err);
          check("done_pulse", bus.done, !e_mon.is_err);
          check("latency", cyc - e_mon.acc_cyc, e_mon.lat);
          check("rd_count", rd_cnt, e_mon.rd);
          if (e_mon.rd) begin
            check("rd_addr", rd_addr, e_mon.addr);
            check("rd_cycle", rd_cyc - e_mon.acc_cyc, 1);
          end
          check("wr_count", wr_cnt, e_mon.wr);
          if (e_mon.wr) begin
            check("wr_addr", wr_addr, e_mon.addr);
            check("wr_data", wr_data, e_mon.wdata);
            check("wr_cycle", wr_cyc - e_mon.acc_cyc, 3);
          end
          chk = e_mon;
          chk_pend = 1;
        end
        rd_cnt = 0; wr_cnt = 0;
      end
    end
  end

  // ---------------- driver
  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
    check("completion_pending", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic issue(input logic [3:0] op, input logic [1:0] mode, input logic [7:0] imm,
                       input logic [15:0] addr, input logic [7:0] rdata, input bit wait_done,
                       output int stall);
    exp_t e;
    int n = 0;
    if (mode != 2'd0) mem[addr] = rdata;
    @(negedge clk);
    bus.req_op = op; bus.req_mode = mode; bus.req_imm = imm; bus.req_addr = addr;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    stall = n;
    if (bus.req_ready) begin
      predict(op, mode, imm, addr, rdata, e);
      e.acc_cyc = cyc;
      exp_q.push_back(e);
      @(posedge clk); #1;
    end else begin
      check("accept_timeout", bus.req_ready, 1);
    end
    bus.req_valid = 1'b0;
    bus.req_op = 4'($urandom); bus.req_mode = 2'($urandom);
    bus.req_imm = 8'($urandom); bus.req_addr = 16'($urandom);
    if (wait_done) wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall, seen_wr, seen_done;
    logic [3:0] op;
    logic [1:0] mode;
    bus.req_valid = 1'b0; bus.req_op = 4'h0; bus.req_mode = 2'h0;
    bus.req_imm = 8'h00; bus.req_addr = 16'h0000; bus.mem_rdata = 8'h00;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ready", bus.req_ready, 1);
    check("rst_acc", bus.acc, 8'h00);
    check("rst_status", bus.status, 4'h0);
    check("rst_mem_rd", bus.mem_rd, 0);
    check("rst_mem_wr", bus.mem_wr, 0);
    check("rst_mem_addr", bus.mem_addr, 16'h0000);
    check("rst_mem_wdata", bus.mem_wdata, 8'h00);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    rst_n = 1'b1;

    // Directed scenarios
    issue(4'd0, 2'd0, 8'h05, 16'h0000, 8'h00, 1, stall);      // ADC #5
    check("s1_acc", bus.acc, 8'h05);
    check("s1_status", bus.status, 4'b0000);
    issue(4'd10, 2'd0, 8'h7F, 16'h0000, 8'h00, 1, stall);     // PASS #7F
    issue(4'd0, 2'd0, 8'h01, 16'h0000, 8'h00, 1, stall);      // ADC #1
    check("s2_acc", bus.acc, 8'h80);
    check("s2_status", bus.status, 4'b1100);
    issue(4'd10, 2'd0, 8'h40, 16'h0000, 8'h00, 1, stall);     // PASS #40
    issue(4'd9, 2'd1, 8'h00, 16'h1234, 8'h40, 1, stall);      // CMP [1234]
    check("s3_acc", bus.acc, 8'h40);
    check("s3_status", bus.status, 4'b0111);
    issue(4'd6, 2'd0, 8'h00, 16'h0000, 8'h00, 1, stall);      // LSR A: clears C
    issue(4'd7, 2'd2, 8'h00, 16'h0200, 8'h80, 1, stall);      // ROL [0200]
    check("s4_acc", bus.acc, 8'h20);
    check("s4_status", bus.status, 4'b0111);
    check("s4_mem", mem[16'h0200] === 8'h80 ? 1 : 0, 1);

    issue(4'hF, 2'd0, 8'h11, 16'h0000, 8'h00, 1, stall);      // illegal op
    issue(4'd2, 2'd2, 8'h00, 16'h0300, 8'h55, 1, stall);      // RMW AND: illegal
    check("ill_acc", bus.acc, 8'h20);
    check("ill_status", bus.status, 4'b0111);

    // Request held valid while a RMW is in flight must wait out READ/EXEC/WRITE
    issue(4'd5, 2'd2, 8'h00, 16'h0300, 8'h81, 0, stall);      // ASL [0300]
    issue(4'd10, 2'd0, 8'h3C, 16'h0500, 8'h00, 1, stall);     // PASS #3C
    check("held_valid_stall", stall, 3);
    check("held_acc", bus.acc, 8'h3C);

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 11));
      if (op == 4'd11) op = 4'($urandom_range(11, 15));
      mode = 2'($urandom_range(0, 3));
      issue(op, mode, 8'($urandom), 16'($urandom), 8'($urandom), 1, stall);
    end

    // Reset during READ of a RMW abandons it
    mem[16'h0400] = 8'hFF;
    @(negedge clk);
    bus.req_op = 4'd7; bus.req_mode = 2'd2; bus.req_addr = 16'h0400; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_in_read", bus.mem_rd, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_acc", bus.acc, 8'h00);
    check("mid_rst_status", bus.status, 4'h0);
    check("mid_rst_mem_rd", bus.mem_rd, 0);
    m_acc = 8'h00; m_n = 0; m_v = 0; m_z = 0; m_c = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_wr = 0; seen_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.mem_wr) seen_wr++;
      if (bus.done) seen_done++;
    end
    check("mid_rst_no_wr", seen_wr, 0);
    check("mid_rst_no_done", seen_done, 0);
    check("mid_rst_ready", bus.req_ready, 1);
    check("mid_rst_acc_after", bus.acc, 8'h00);
    check("mid_rst_status_after", bus.status, 4'h0);

    // Sequencer still works after the abandoned op
    issue(4'd0, 2'd0, 8'h09, 16'h0000, 8'h00, 1, stall);
    check("post_rst_acc", bus.acc, 8'h09);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
